axi4_stream_fifo: RTL and testbench

Parametrised AXI4-Stream FIFO: generalises the single-entry stream buffer to a configurable data width and a power-of-two depth, and adds end-of-packet (last) transport, a fill-level output and an almost-full flag. It sits between any stream producer and consumer in the datapath and sustains one transfer per clock on each side. An optional packet mode holds output until a complete packet is stored.

---
 rtl/axi4_stream_fifo.sv | 119 +++++++++++
 tb/tb_axi4_stream_fifo.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_fifo.sv
// AXI4-Stream FIFO carrying {last, data}, with fill level and almost-full flag.
// Optional packet mode (output held until a whole packet is stored): define AXI4_STREAM_FIFO_PACKET_MODE_EN.
module axi4_stream_fifo #(
  parameter int DATA_SIZE         = 32,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [DATA_SIZE-1:0]       read_data,
  input  logic                       read_data_last,
  input  logic                       read_data_valid,
  output logic                       read_data_ready,
  output logic [DATA_SIZE-1:0]       write_data,
  output logic                       write_data_last,
  output logic                       write_data_valid,
  input  logic                       write_data_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int EW = DATA_SIZE + 1;
  localparam logic [LW-1:0] AF_THRESH = LW'(ALMOST_FULL_LEVEL);

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] mem_q;
  logic [EW-1:0] bypass_data_reg;
  logic          bypass_reg;
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          ready_reg;
  logic          full_next;
  logic          push, pop, empty;
  logic          head_is_new;

  assign push  = read_data_valid & ready_reg;
  assign pop   = write_data_valid & write_data_ready;
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  always_comb begin
    wr_ptr_next = wr_ptr_reg + {{(PW-1){1'b0}}, push};
    rd_ptr_next = rd_ptr_reg + {{(PW-1){1'b0}}, pop};
    full_next   = (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]) &&
                  (wr_ptr_next[AW] != rd_ptr_next[AW]);
  end

  // The word being written becomes the head when the FIFO drains to exactly it.
  assign head_is_new = push && (wr_ptr_reg == rd_ptr_next);

  // Plain RAM with registered read; a same-cycle write to the head is forwarded separately.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {read_data_last, read_data};
    end
    mem_q <= mem[rd_ptr_next[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    bypass_data_reg <= {read_data_last, read_data};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ready_reg  <= 1'b0;
      bypass_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      ready_reg  <= !full_next;
      bypass_reg <= head_is_new;
    end
  end

  assign head            = bypass_reg ? bypass_data_reg : mem_q;
  assign write_data      = head[DATA_SIZE-1:0];
  assign write_data_last = head[DATA_SIZE];
  assign read_data_ready = ready_reg;
  assign level           = LW'(wr_ptr_reg - rd_ptr_reg);
  assign almost_full     = (level >= AF_THRESH);

`ifdef AXI4_STREAM_FIFO_PACKET_MODE_EN
  logic          full;
  logic [LW-1:0] pkt_count_reg, pkt_count_next;
  logic          push_last, pop_last;

  assign full      = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign push_last = push & read_data_last;
  assign pop_last  = pop & write_data_last;

  always_comb begin
    pkt_count_next = pkt_count_reg;
    if (push_last && !pop_last) begin
      pkt_count_next = pkt_count_reg + LW'(1);
    end else if (!push_last && pop_last) begin
      pkt_count_next = pkt_count_reg - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pkt_count_reg <= '0;
    end else begin
      pkt_count_reg <= pkt_count_next;
    end
  end

  // A full FIFO releases data even without a stored last, so oversize packets cannot deadlock.
  assign write_data_valid = !empty && ((pkt_count_reg != '0) || full);
`else
  assign write_data_valid = !empty;
`endif

endmodule

// File: tb/tb_axi4_stream_fifo.sv
// Bench for axi4_stream_fifo: vector table, corner sequences and a random stream
// checked against a queue model of the FIFO.
module tb_axi4_stream_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int NV    = 13;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] read_data = '0;
  logic          read_data_last = 1'b0;
  logic          read_data_valid = 1'b0;
  logic          read_data_ready;
  logic [DW-1:0] write_data;
  logic          write_data_last;
  logic          write_data_valid;
  logic          write_data_ready = 1'b0;
  logic [LW-1:0] level;
  logic          almost_full;

  int total = 0;
  int bad = 0;
  int rx_count = 0;

  logic [DW:0] q[$];
  bit          m_ready = 1'b0;

  typedef struct {
    logic          rn;
    logic          v;
    logic [DW-1:0] d;
    logic          l;
    logic          r;
    logic          e_ready;
    logic          e_valid;
    logic [LW-1:0] e_level;
    logic [DW-1:0] e_data;
    logic          e_last;
  } vec_t;

  vec_t vecs[NV];

  always #5 clk = ~clk;

  axi4_stream_fifo #(
    .DATA_SIZE(DW),
    .DEPTH(DEPTH),
    .ALMOST_FULL_LEVEL(DEPTH - 2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .read_data(read_data),
    .read_data_last(read_data_last),
    .read_data_valid(read_data_valid),
    .read_data_ready(read_data_ready),
    .write_data(write_data),
    .write_data_last(write_data_last),
    .write_data_valid(write_data_valid),
    .write_data_ready(write_data_ready),
    .level(level),
    .almost_full(almost_full)
  );

  function automatic vec_t mkv(input logic rn, input logic v, input logic [DW-1:0] d,
                               input logic l, input logic r, input logic er, input logic ev,
                               input logic [LW-1:0] el, input logic [DW-1:0] ed, input logic eal);
    vec_t t;
    t.rn = rn; t.v = v; t.d = d; t.l = l; t.r = r;
    t.e_ready = er; t.e_valid = ev; t.e_level = el; t.e_data = ed; t.e_last = eal;
    return t;
  endfunction

  // Output is offered when anything is stored; packet mode also needs a complete
  // packet in storage, or a completely full FIFO.
  function automatic bit model_valid();
`ifdef AXI4_STREAM_FIFO_PACKET_MODE_EN
    int n = 0;
    foreach (q[i]) if (q[i][DW]) n++;
    return (q.size() > 0) && (n > 0 || q.size() == DEPTH);
`else
    return q.size() > 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic rn, input logic v, input logic [DW-1:0] d,
                      input logic l, input logic r);
    bit          m_push;
    bit          m_pop;
    logic [DW:0] popped;
    resetn           = rn;
    read_data_valid  = v;
    read_data        = d;
    read_data_last   = l;
    write_data_ready = r;
    m_push = v && m_ready;
    m_pop  = model_valid() && r;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      m_ready = 1'b0;
    end else begin
      if (m_pop) begin
        popped = q.pop_front();
        rx_count++;
        $display("xfer %0d: out data=%0h last=%0b", rx_count, popped[DW-1:0], popped[DW]);
      end
      if (m_push) q.push_back({l, d});
      m_ready = (q.size() < DEPTH);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    bit mv;
    mv = model_valid();
    chk({tag, " ready"}, 64'(read_data_ready), 64'(m_ready));
    chk({tag, " valid"}, 64'(write_data_valid), 64'(mv));
    chk({tag, " level"}, 64'(level), 64'(q.size()));
    chk({tag, " almost_full"}, 64'(almost_full), 64'(q.size() >= DEPTH - 2));
    if (mv) begin
      chk({tag, " data"}, 64'(write_data), 64'(q[0][DW-1:0]));
      chk({tag, " last"}, 64'(write_data_last), 64'(q[0][DW]));
    end
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_model("reset");
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_model("release");
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      tick(1'b1, 1'b0, '0, 1'b0, 1'b1);
      check_model(tag);
      n++;
    end
    chk({tag, " empty"}, 64'(level), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rn v d l r | ready valid level data last
    vecs[0]  = mkv(0, 1,  5, 0, 0,  0, 0, 0,  0, 0);
    vecs[1]  = mkv(0, 1,  5, 0, 0,  0, 0, 0,  0, 0);
    vecs[2]  = mkv(0, 1,  5, 0, 0,  0, 0, 0,  0, 0);
    vecs[3]  = mkv(1, 0,  0, 0, 0,  1, 0, 0,  0, 0);
    vecs[4]  = mkv(1, 1, 10, 1, 0,  1, 1, 1, 10, 1);
    vecs[5]  = mkv(1, 0,  0, 0, 1,  1, 0, 0,  0, 0);
    vecs[6]  = mkv(1, 1, 20, 1, 1,  1, 1, 1, 20, 1);
    vecs[7]  = mkv(1, 1, 21, 1, 1,  1, 1, 1, 21, 1);
    vecs[8]  = mkv(1, 0,  0, 0, 1,  1, 0, 0,  0, 0);
    vecs[9]  = mkv(0, 1, 30, 1, 0,  0, 0, 0,  0, 0);
    vecs[10] = mkv(1, 1, 31, 1, 0,  1, 0, 0,  0, 0);
    vecs[11] = mkv(1, 1, 31, 1, 0,  1, 1, 1, 31, 1);
    vecs[12] = mkv(0, 0,  0, 0, 0,  0, 0, 0,  0, 0);

    for (int i = 0; i < NV; i++) begin
      tick(vecs[i].rn, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
      $display("vec %0d: ready=%0b valid=%0b level=%0d", i, read_data_ready, write_data_valid, level);
      chk($sformatf("vec%0d ready", i), 64'(read_data_ready), 64'(vecs[i].e_ready));
      chk($sformatf("vec%0d valid", i), 64'(write_data_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d level", i), 64'(level), 64'(vecs[i].e_level));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d data", i), 64'(write_data), 64'(vecs[i].e_data));
        chk($sformatf("vec%0d last", i), 64'(write_data_last), 64'(vecs[i].e_last));
      end
      check_model($sformatf("vec%0d model", i));
    end

    // Fill with consumer stalled, hold one extra word, then drain.
    begin : fill_drain
      int  start;
      int  n;
      bit  v16;
      bit  acc;
      do_reset();
      start = rx_count;
      for (int i = 0; i < DEPTH; i++) begin
        tick(1'b1, 1'b1, DW'(i), (i == DEPTH - 1), 1'b0);
        check_model("fill");
      end
      chk("fill level", 64'(level), 64'(DEPTH));
      chk("fill ready", 64'(read_data_ready), 64'(0));
      chk("fill almost_full", 64'(almost_full), 64'(1));
      for (int i = 0; i < 2; i++) begin
        tick(1'b1, 1'b1, DW'(16), 1'b1, 1'b0);
        check_model("full hold");
      end
      v16 = 1'b1;
      n = 0;
      while ((v16 || q.size() > 0) && n < 100) begin
        acc = v16 && m_ready;
        tick(1'b1, v16, DW'(16), 1'b1, 1'b1);
        check_model("drain");
        if (acc) v16 = 1'b0;
        n++;
      end
      chk("fill drained words", 64'(rx_count - start), 64'(DEPTH + 1));
    end

    // Simultaneous push and pop at a steady level of 8.
    begin : steady
      int start;
      do_reset();
      for (int i = 0; i < 8; i++) begin
        tick(1'b1, 1'b1, DW'(200 + i), 1'b1, 1'b0);
        check_model("prefill");
      end
      start = rx_count;
      for (int k = 0; k < 20; k++) begin
        tick(1'b1, 1'b1, DW'(300 + k), 1'b1, 1'b1);
        check_model("steady");
        chk("steady level", 64'(level), 64'(8));
      end
      chk("steady pops", 64'(rx_count - start), 64'(20));
      drain("steady drain");
    end

    // Random stream of 1000 incrementing words with gaps on both sides.
    begin : stream
      int start;
      int sent;
      int cyc;
      int max_level;
      bit v;
      bit cl;
      bit r;
      bit acc;
      do_reset();
      start = rx_count;
      sent = 0;
      cyc = 0;
      max_level = 0;
      v = 1'b0;
      cl = ($urandom_range(0, 4) == 0);
      while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
        if (!v && sent < 1000) v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) != 0);
        acc = v && m_ready;
        tick(1'b1, v, DW'(sent), cl || (sent == 999), r);
        check_model("stream");
        if (int'(level) > max_level) max_level = int'(level);
        if (acc) begin
          sent++;
          v = 1'b0;
          cl = ($urandom_range(0, 4) == 0);
        end
        cyc++;
      end
      chk("stream words", 64'(rx_count - start), 64'(1000));
      chk("stream level bound", 64'(max_level <= DEPTH), 64'(1));
    end

`ifdef AXI4_STREAM_FIFO_PACKET_MODE_EN
    begin : packet
      int  start;
      int  sent;
      int  n;
      bit  acc;
      do_reset();
      start = rx_count;
      for (int d = 8; d <= 14; d++) begin
        tick(1'b1, 1'b1, DW'(d), (d == 14), 1'b1);
        check_model("pkt7");
        if (d < 14) chk("pkt7 held", 64'(write_data_valid), 64'(0));
      end
      drain("pkt7 drain");
      chk("pkt7 words", 64'(rx_count - start), 64'(7));

      start = rx_count;
      sent = 0;
      n = 0;
      while ((sent < 20 || q.size() > 0) && n < 400) begin
        acc = (sent < 20) && m_ready;
        tick(1'b1, (sent < 20), DW'(500 + sent), (sent == 19), 1'b1);
        check_model("pkt20");
        if (acc) sent++;
        n++;
      end
      chk("pkt20 words", 64'(rx_count - start), 64'(20));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
